multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencer for the multi-cycle MIPS32 datapath (shared ALU, single unified memory, IR/ALUOut/MDR holding registers).
- Supports R-type, ADDI, SLTI, LW, SW, BEQ, BNE and J.
- Drives every datapath mux and write enable, stalls on a memory ready handshake, and counts retired instructions.

Parameters:
- USE_MEM_READY, 1: when 0, mem_ready is ignored and treated as constant 1, for single-cycle memories.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  6  IR[31:26]; driven from the registered IR, so it is stable from DECODE until the next fetch completes.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by the ALU zero flag in the datapath.
- BranchNe  out  1  inverts the zero qualification (BNE).
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- MemToReg  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  2  ALU operation: 00 = add, 01 = subtract, 10 = use funct field, 11 = set-less-than.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky unsupported-opcode flag.
- retired_cnt  out  CNT_W  count of retired instructions.
- state  out  4  current state, for debug.

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = START (0).
  - All control outputs 0, retired_cnt = 0, illegal_op = 0.
  - Reset may arrive mid-instruction; the in-flight instruction is abandoned with no write strobe issued after assertion.
- State register is clocked. All outputs are combinational decodes of state (plus Opcode where noted); any signal not listed for a state is 0.
- START(0): all outputs 0; next state FETCH.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - If mem_ready: IRWrite=1, PCWrite=1, PCSrc=00; next DECODE.
  - Otherwise stay in FETCH with IRWrite=0 and PCWrite=0.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 100011 (LW) or 101011 (SW) -> MEMADR.
  - 000000 (R-type) -> EXEC_R.
  - 001000 (ADDI) or 001010 (SLTI) -> EXEC_I.
  - 000100 (BEQ) or 000101 (BNE) -> BRANCH.
  - 000010 (J) -> JUMP.
  - any other opcode -> TRAP.
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEM_RD if LW, MEM_WR if SW.
- MEM_RD(4): IorD=1, MemRead=1. Hold until mem_ready, then WB_MEM.
- WB_MEM(5): RegDst=0, MemToReg=1, RegWrite=1. Next FETCH.
- MEM_WR(6): IorD=1, MemWrite=1. Hold until mem_ready, then FETCH.
- EXEC_R(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next WB_R.
- WB_R(8): RegDst=1, MemToReg=0, RegWrite=1. Next FETCH.
- EXEC_I(9): ALUSrcA=1, ALUSrcB=10; ALUOp=11 when Opcode=001010, else 00. Next WB_I.
- WB_I(10): RegDst=0, MemToReg=0, RegWrite=1. Next FETCH.
- BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, BranchNe=Opcode[0]. Next FETCH.
- JUMP(12): PCWrite=1, PCSrc=10. Next FETCH.
- TRAP(13): all strobes 0; illegal_op is set on entry and stays set. TRAP is terminal until reset.
- Unused encodings 14 and 15 go to START.
- Retirement:
  - instr_done = 1 on any transition from WB_MEM, MEM_WR (with mem_ready), WB_R, WB_I, BRANCH or JUMP into FETCH.
  - retired_cnt increments on the same edge and wraps modulo 2^CNT_W.
- Latency with mem_ready held at 1:
  - R-type, ADDI, SLTI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Each low cycle of mem_ready in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- Strobe and stall rules:
  - MemRead and MemWrite are never asserted in the same cycle.
  - RegWrite is never asserted with MemWrite.
  - While stalled, outputs remain constant.

Test Plan:
- Reset release, mem_ready=1, Opcode=000000 -> states 0,1,2,7,8,1. RegDst=1 and RegWrite=1 in state 8. instr_done pulses once. retired_cnt=1.
- Opcode=100011, mem_ready low for 2 cycles in MEM_RD -> state 4 is held 3 cycles. MemToReg=1 and RegWrite=1 in state 5. Total 7 cycles.
- Opcode=000101 -> in BRANCH: PCWriteCond=1, BranchNe=1, PCSrc=01, ALUOp=01. With Opcode=000100, BranchNe=0.
- Opcode=001010 -> ALUOp=11 in EXEC_I. Opcode=001000 -> ALUOp=00. Both then write with RegDst=0.
- Opcode=111111 -> TRAP. illegal_op=1 and stays set for 100 cycles with no strobes. Pulsing rst_n clears it to 0 and returns to START.
- rst_n asserted asynchronously mid-MEM_WR -> MemWrite falls immediately without waiting for clk. state=0 and retired_cnt=0. A counter preloaded by 2^CNT_W retirements wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS32 control sequencer with memory stall and retire counter
module multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEM_RD = 4'd4,
    S_WB_MEM = 4'd5,
    S_MEM_WR = 4'd6,
    S_EXEC_R = 4'd7,
    S_WB_R   = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13,
    S_RSV14  = 4'd14,
    S_RSV15  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  logic             w_ready;

  assign w_ready     = USE_MEM_READY ? mem_ready : 1'b1;
  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign retired_cnt = r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_START;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (w_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      // Branch target is computed speculatively here so BRANCH only needs the compare.
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_RTYPE:         w_next = S_EXEC_R;
          OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (w_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (w_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_WB_R;
      end
      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Opcode == OP_SLTI) ? 2'b11 : 2'b00;
        w_next  = S_WB_I;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        BranchNe    = Opcode[0];
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_START;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    Opcode = 6'd0;
  logic          mem_ready = 1'b1;
  logic          PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic          RegDst, MemToReg, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0]    PCSrc, ALUSrcB, ALUOp;
  logic [CW-1:0] retired_cnt;
  logic [3:0]    state;

  multicycle_control #(.USE_MEM_READY(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .PCSrc(PCSrc),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, bne;
    logic [1:0] pcsrc;
    logic       iord, mr, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop;
    logic       done;
  } ctrl_t;

  ctrl_t w_ctrl;
  assign w_ctrl = {PCWrite, PCWriteCond, BranchNe, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done};

  int checks = 0;
  int failures = 0;

  ctrl_t         e_ctrl = '0;
  logic [3:0]    e_state = 4'd0;
  logic          e_ill = 1'b0;
  logic [CW-1:0] e_cnt = '0;
  logic          chk_en = 1'b0;
  int            lat = 0;
  int            last_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 32'(w_ctrl), 32'(e_ctrl));
      check("state", 32'(state), 32'(e_state));
      check("illegal_op", 32'(illegal_op), 32'(e_ill));
      check("retired_cnt", 32'(retired_cnt), 32'(e_cnt));
    end
  end

  // Cycles from the first FETCH after START (or after the previous retirement) to retirement.
  always @(negedge clk) begin
    if (state == 4'd0) lat = 0;
    else lat = lat + 1;
    if (instr_done) begin
      last_lat = lat;
      lat = 0;
    end
  end

  task automatic step(input logic [3:0] st, input ctrl_t c, input logic mr);
    mem_ready = mr;
    e_state   = st;
    e_ctrl    = c;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if (c.done) e_cnt = e_cnt + 1'b1;
  endtask

  task automatic fetch_decode(input int fst, input logic mr_idle);
    ctrl_t c;
    for (int i = 0; i < fst; i++) begin
      c = '0; c.mr = 1; c.asb = 2'b01;
      step(4'd1, c, 1'b0);
    end
    c = '0; c.mr = 1; c.asb = 2'b01; c.irw = 1; c.pcw = 1;
    step(4'd1, c, 1'b1);
    c = '0; c.asb = 2'b11;
    step(4'd2, c, mr_idle);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                           input logic mr_idle, input int trap_cycles);
    ctrl_t c;
    Opcode = op;
    fetch_decode(fst, mr_idle);
    case (op)
      6'b100011, 6'b101011: begin
        c = '0; c.asa = 1; c.asb = 2'b10;
        step(4'd3, c, mr_idle);
        c = '0; c.iord = 1;
        if (op == 6'b100011) c.mr = 1; else c.mw = 1;
        for (int i = 0; i < mst; i++) step(op == 6'b100011 ? 4'd4 : 4'd6, c, 1'b0);
        if (op == 6'b100011) begin
          step(4'd4, c, 1'b1);
          c = '0; c.m2r = 1; c.rw = 1; c.done = 1;
          step(4'd5, c, mr_idle);
        end else begin
          c.done = 1;
          step(4'd6, c, 1'b1);
        end
      end
      6'b000000: begin
        c = '0; c.asa = 1; c.aop = 2'b10;
        step(4'd7, c, mr_idle);
        c = '0; c.rdst = 1; c.rw = 1; c.done = 1;
        step(4'd8, c, mr_idle);
      end
      6'b001000, 6'b001010: begin
        c = '0; c.asa = 1; c.asb = 2'b10; c.aop = (op == 6'b001010) ? 2'b11 : 2'b00;
        step(4'd9, c, mr_idle);
        c = '0; c.rw = 1; c.done = 1;
        step(4'd10, c, mr_idle);
      end
      6'b000100, 6'b000101: begin
        c = '0; c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.bne = op[0]; c.done = 1;
        step(4'd11, c, mr_idle);
      end
      6'b000010: begin
        c = '0; c.pcw = 1; c.pcsrc = 2'b10; c.done = 1;
        step(4'd12, c, mr_idle);
      end
      default: begin
        e_ill = 1'b1;
        for (int i = 0; i < trap_cycles; i++) step(4'd13, '0, (i % 3) == 0);
      end
    endcase
  endtask

  task automatic release_reset();
    e_ctrl = '0; e_state = 4'd0; e_ill = 1'b0; e_cnt = '0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, '0, 1'b1);
  endtask

  task automatic async_reset_check(input string tag);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
    check({tag, "_retired"}, 32'(retired_cnt), 32'd0);
  endtask

  initial begin
    ctrl_t c;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, '0, 1'b1);

    run_instr(6'b000000, 0, 0, 1'b1, 0);
    check("lat_rtype", 32'(last_lat), 32'd4);
    check("cnt_after_r", 32'(retired_cnt), 32'd1);
    check("state_after_r", 32'(state), 32'd1);

    run_instr(6'b100011, 0, 2, 1'b1, 0);
    check("lat_lw_stall2", 32'(last_lat), 32'd7);
    run_instr(6'b000101, 0, 0, 1'b0, 0);
    check("lat_bne", 32'(last_lat), 32'd3);
    run_instr(6'b000100, 0, 0, 1'b1, 0);
    run_instr(6'b001010, 0, 0, 1'b0, 0);
    check("lat_slti", 32'(last_lat), 32'd4);
    run_instr(6'b001000, 0, 0, 1'b1, 0);
    run_instr(6'b101011, 1, 1, 1'b1, 0);
    check("lat_sw_stall", 32'(last_lat), 32'd6);
    run_instr(6'b000010, 0, 0, 1'b0, 0);
    check("lat_j", 32'(last_lat), 32'd3);
    run_instr(6'b100011, 0, 0, 1'b1, 0);
    check("lat_lw", 32'(last_lat), 32'd5);
    check("cnt_after_9", 32'(retired_cnt), 32'd9);

    for (int i = 0; i < 7; i++) run_instr(6'b000010, 0, 0, 1'b1, 0);
    check("cnt_wrap", 32'(retired_cnt), 32'd0);
    run_instr(6'b000000, 0, 0, 1'b1, 0);
    check("cnt_post_wrap", 32'(retired_cnt), 32'd1);

    Opcode = 6'b101011;
    fetch_decode(0, 1'b1);
    c = '0; c.asa = 1; c.asb = 2'b10;
    step(4'd3, c, 1'b1);
    mem_ready = 1'b0;
    chk_en = 1'b0;
    check("memwr_before_rst", 32'(MemWrite), 32'd1);
    async_reset_check("rst_memwr");
    release_reset();

    run_instr(6'b111111, 0, 0, 1'b1, 100);
    check("trap_sticky", 32'(illegal_op), 32'd1);
    async_reset_check("rst_trap");
    release_reset();

    run_instr(6'b000000, 0, 0, 1'b1, 0);
    check("cnt_after_trap_reset", 32'(retired_cnt), 32'd1);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
